// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl: 2-way set-associative, write-through, no-write-allocate
// data cache controller sitting in the MEM stage of a pipeline.
// A read hit returns data combinationally in the same cycle. A read miss
// fills a whole line from the SRAM controller. Writes always go to SRAM,
// and they update the cached copy only when the line is present.
// Optional feature: define CACHE_STATS_EN to enable the hit/miss counters.
module assoc_cache_ctrl #(
    parameter int SETS_LOG2       = 6,
    parameter int LINE_WORDS_LOG2 = 1,
    parameter int ADDR_W          = 18
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rd_en,
    input  logic                            wr_en,
    input  logic [31:0]                     addr,
    input  logic [31:0]                     wdata,
    output logic [31:0]                     rdata,
    output logic                            pause,
    output logic                            sram_rd_req,
    output logic                            sram_wr_req,
    output logic [31:0]                     sram_addr,
    output logic [31:0]                     sram_wdata,
    input  logic [32*(1<<LINE_WORDS_LOG2)-1:0] sram_rdata,
    input  logic                            sram_ready,
    output logic [31:0]                     hit_cnt,
    output logic [31:0]                     miss_cnt
);
    localparam int LW     = 1 << LINE_WORDS_LOG2;
    localparam int SETS   = 1 << SETS_LOG2;
    localparam int IDX_LO = LINE_WORDS_LOG2 + 2;
    localparam int TAG_LO = IDX_LO + SETS_LOG2;
    localparam int TAG_W  = ADDR_W - TAG_LO;
    localparam int OW     = (LINE_WORDS_LOG2 > 0) ? LINE_WORDS_LOG2 : 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t                r_state, w_next;
    logic [SETS-1:0]       r_val0, r_val1, r_lru;
    logic [TAG_W-1:0]      r_tag0 [SETS];
    logic [TAG_W-1:0]      r_tag1 [SETS];
    logic [LW-1:0][31:0]   r_data0 [SETS];
    logic [LW-1:0][31:0]   r_data1 [SETS];

    logic [SETS_LOG2-1:0]  w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [OW-1:0]         w_off;
    logic [LW-1:0][31:0]   w_fill_line;
    logic                  w_hit0, w_hit1, w_hit, w_victim;
    logic [31:0]           w_hit_word;
    logic                  w_fill_we, w_wr_we, w_lru_we, w_lru_val;
    logic                  w_hit_evt, w_miss_evt;

    assign w_idx       = addr[TAG_LO-1:IDX_LO];
    assign w_tag       = addr[ADDR_W-1:TAG_LO];
    assign w_off       = OW'((addr >> 2) & 32'(LW - 1));
    assign w_fill_line = sram_rdata;
    assign w_hit0      = r_val0[w_idx] && (r_tag0[w_idx] == w_tag);
    assign w_hit1      = r_val1[w_idx] && (r_tag1[w_idx] == w_tag);
    assign w_hit       = w_hit0 | w_hit1;
    // Invalid way 0 first, then invalid way 1, else the LRU way.
    assign w_victim    = !r_val0[w_idx] ? 1'b0 : (!r_val1[w_idx] ? 1'b1 : r_lru[w_idx]);
    assign w_hit_word  = w_hit1 ? r_data1[w_idx][w_off] : r_data0[w_idx][w_off];

    // State register; reset abandons any in-flight SRAM transaction.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state, handshake outputs and array write enables.
    always_comb begin
        w_next      = r_state;
        pause       = 1'b0;
        sram_rd_req = 1'b0;
        sram_wr_req = 1'b0;
        sram_addr   = 32'd0;
        sram_wdata  = 32'd0;
        rdata       = 32'd0;
        w_fill_we   = 1'b0;
        w_wr_we     = 1'b0;
        w_lru_we    = 1'b0;
        w_lru_val   = 1'b0;
        w_hit_evt   = 1'b0;
        w_miss_evt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (wr_en) begin
                    pause  = 1'b1;
                    w_next = WRITE;
                end else if (rd_en) begin
                    if (w_hit) begin
                        rdata     = w_hit_word;
                        w_lru_we  = 1'b1;
                        w_lru_val = ~w_hit1;
                        w_hit_evt = 1'b1;
                    end else begin
                        pause      = 1'b1;
                        w_miss_evt = 1'b1;
                        w_next     = FILL;
                    end
                end
            end
            FILL: begin
                sram_rd_req = 1'b1;
                sram_addr   = {addr[31:IDX_LO], {IDX_LO{1'b0}}};
                pause       = 1'b1;
                if (sram_ready) begin
                    w_fill_we = 1'b1;
                    w_lru_we  = 1'b1;
                    w_lru_val = ~w_victim;
                    rdata     = w_fill_line[w_off];
                    pause     = 1'b0;
                    w_next    = IDLE;
                end
            end
            WRITE: begin
                sram_wr_req = 1'b1;
                sram_addr   = addr;
                sram_wdata  = wdata;
                pause       = 1'b1;
                if (sram_ready) begin
                    w_wr_we   = w_hit;
                    w_lru_we  = w_hit;
                    w_lru_val = ~w_hit1;
                    pause     = 1'b0;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Valid and LRU bits: the only array state that needs reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_val0 <= '0;
            r_val1 <= '0;
            r_lru  <= '0;
        end else begin
            if (w_fill_we) begin
                if (w_victim) r_val1[w_idx] <= 1'b1;
                else          r_val0[w_idx] <= 1'b1;
            end
            if (w_lru_we) r_lru[w_idx] <= w_lru_val;
        end
    end

    // Tag and data arrays: line fill into the victim, word update on write hit.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            if (w_victim) begin
                r_data1[w_idx] <= w_fill_line;
                r_tag1[w_idx]  <= w_tag;
            end else begin
                r_data0[w_idx] <= w_fill_line;
                r_tag0[w_idx]  <= w_tag;
            end
        end
        if (w_wr_we) begin
            if (w_hit1) r_data1[w_idx][w_off] <= wdata;
            else        r_data0[w_idx][w_off] <= wdata;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    // Statistics counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= 32'd0;
            r_miss_cnt <= 32'd0;
        end else begin
            if (w_hit_evt)  r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (w_miss_evt) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    logic w_unused_evt;
    assign w_unused_evt = w_hit_evt ^ w_miss_evt;
    assign hit_cnt      = 32'd0;
    assign miss_cnt     = 32'd0;
`endif

endmodule
